// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stack_pkg
// Purpose : Shared definitions for the StackArch operand stack: op encodings
//           and the per-op legality lookup (minimum entries / growth).
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package stack_pkg;

   // Op encoding presented on op[2:0] by the control unit
   localparam logic [2:0] OP_NOP     = 3'd0;
   localparam logic [2:0] OP_PUSH    = 3'd1;
   localparam logic [2:0] OP_DROP    = 3'd2;
   localparam logic [2:0] OP_DUP     = 3'd3;
   localparam logic [2:0] OP_SWAP    = 3'd4;
   localparam logic [2:0] OP_OVER    = 3'd5;
   localparam logic [2:0] OP_REDUCE  = 3'd6;
   localparam logic [2:0] OP_REPLACE = 3'd7;

   // Legality requirements of one op
   typedef struct packed {
      logic [1:0] min_entries;  // entries that must already be on the stack
      logic       grows;        // op adds one entry, so it needs a free slot
   } op_req_t;

   function automatic op_req_t op_req(input logic [2:0] op);
      op_req_t r;
      r.min_entries = 2'd0;
      r.grows       = 1'b0;
      case (op)
         OP_PUSH: begin
            r.grows = 1'b1;
         end
         OP_DROP: begin
            r.min_entries = 2'd1;
         end
         OP_DUP: begin
            r.min_entries = 2'd1;
            r.grows       = 1'b1;
         end
         OP_SWAP: begin
            r.min_entries = 2'd2;
         end
         OP_OVER: begin
            r.min_entries = 2'd2;
            r.grows       = 1'b1;
         end
         OP_REDUCE: begin
            r.min_entries = 2'd2;
         end
         OP_REPLACE: begin
            r.min_entries = 2'd1;
         end
         default: begin
            r.min_entries = 2'd0;
         end
      endcase
      return r;
   endfunction

endpackage : stack_pkg
`default_nettype wire

// File: rtl/stack_if.sv
`default_nettype none
// ============================================================================
// Module  : stack_if
// Purpose : Op request / stack status bundle between the CPU control unit
//           (master) and the operand stack (slave).
// Ports   : master drives op_valid, op, push_data, alu_result, err_clr;
//           slave drives op_ready, tos, nos, count, empty, full,
//           overflow, underflow.
// Revision: 1.0  initial release
// ============================================================================
interface stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             op_valid;
   logic             op_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] push_data;
   logic [WIDTH-1:0] alu_result;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             overflow;
   logic             underflow;
   logic             err_clr;

   modport master (
      output op_valid, op, push_data, alu_result, err_clr,
      input  op_ready, tos, nos, count, empty, full, overflow, underflow
   );

   modport slave (
      input  op_valid, op, push_data, alu_result, err_clr,
      output op_ready, tos, nos, count, empty, full, overflow, underflow
   );

endinterface : stack_if
`default_nettype wire

// File: rtl/stack_spill_rf.sv
`default_nettype none
// ============================================================================
// Module  : stack_spill_rf
// Purpose : Spill storage for stack entries below tos/nos. DEPTH-2 words,
//           one synchronous write at ptr_i, one asynchronous read at ptr_i-1.
// Ports   : clk      - clock, rising edge
//           we_i     - write enable
//           ptr_i    - spill pointer (count-2 of the owning stack)
//           wdata_i  - word written at ptr_i
//           rdata_o  - word stored at ptr_i-1 (0 when that slot is absent)
// Revision: 1.0  initial release
// ============================================================================
module stack_spill_rf #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       we_i,
   input  logic [$clog2(DEPTH)-1:0]   ptr_i,
   input  logic [WIDTH-1:0]           wdata_i,
   output logic [WIDTH-1:0]           rdata_o
);

   localparam int ENTRIES = DEPTH - 2;
   localparam int PW      = $clog2(DEPTH);
   localparam int AW      = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

   // Contents are don't-care after reset, so the array carries no reset.
   logic [WIDTH-1:0] mem_q [ENTRIES];
   logic [PW-1:0]    w_rd_ptr;

   assign w_rd_ptr = ptr_i - PW'(1);

   // The range guards only matter when the stack holds fewer than three
   // entries; the owning stack never uses the read data in that case, and
   // its legality checks keep writes in range.
   always_ff @(posedge clk) begin
      if (we_i && (ptr_i < PW'(ENTRIES))) begin
         mem_q[ptr_i[AW-1:0]] <= wdata_i;
      end
   end

   assign rdata_o = (w_rd_ptr < PW'(ENTRIES)) ? mem_q[w_rd_ptr[AW-1:0]] : '0;

endmodule : stack_spill_rf
`default_nettype wire

// File: rtl/stack_unit.sv
`default_nettype none
// ============================================================================
// Module  : stack_unit
// Purpose : Parametrised operand stack. tos/nos live in registers, deeper
//           entries spill to stack_spill_rf. Supports PUSH/DROP/DUP/SWAP/
//           OVER/REDUCE/REPLACE, sticky overflow/underflow flags and an
//           optional halt-on-error handshake.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous, active-low reset
//           bus  - stack_if.slave: op request in, stack status out
// Revision: 1.0  initial release
// ============================================================================
module stack_unit
   import stack_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 16,   // power of two, >= 4
   parameter int HALT_ON_ERR = 1
) (
   input  logic    clk,
   input  logic    rst,
   stack_if.slave  bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int PW = $clog2(DEPTH);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [WIDTH-1:0] nos_q, nos_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // ---------------------------------------------------------------------
   // Combinational helpers
   // ---------------------------------------------------------------------
   op_req_t          w_req;
   logic             w_ready;
   logic             w_fire;
   logic             w_set_unf;
   logic             w_set_ovf;
   logic             w_exec;
   logic             w_spill_we;
   logic [PW-1:0]    w_spill_ptr;
   logic [WIDTH-1:0] w_spill_rdata;
   logic [WIDTH-1:0] w_refill;

   // Pointer equals count-2; only the low PW bits matter because the
   // value never exceeds DEPTH-2 whenever the file is actually accessed.
   assign w_spill_ptr = cnt_q[PW-1:0] - PW'(2);

   // Third entry (new nos after a pop) comes from the spill file only if
   // one exists; otherwise nos must read as zero.
   assign w_refill = (cnt_q >= CW'(3)) ? w_spill_rdata : '0;

   if (HALT_ON_ERR != 0) begin : g_halt
      assign w_ready = ~(ovf_q | unf_q);
   end else begin : g_no_halt
      assign w_ready = 1'b1;
   end

   // ---------------------------------------------------------------------
   // Legality and next-state
   // ---------------------------------------------------------------------
   always_comb begin
      w_req      = op_req(bus.op);
      w_fire     = bus.op_valid & w_ready;
      // Underflow takes priority so an op raises at most one flag.
      w_set_unf  = w_fire & (cnt_q < CW'(w_req.min_entries));
      w_set_ovf  = w_fire & ~w_set_unf & w_req.grows & (cnt_q == CW'(DEPTH));
      w_exec     = w_fire & ~w_set_unf & ~w_set_ovf;

      tos_d      = tos_q;
      nos_d      = nos_q;
      cnt_d      = cnt_q;
      w_spill_we = 1'b0;

      if (w_exec) begin
         case (bus.op)
            OP_PUSH: begin
               tos_d      = bus.push_data;
               nos_d      = tos_q;
               cnt_d      = cnt_q + CW'(1);
               w_spill_we = (cnt_q >= CW'(2));
            end
            OP_DROP: begin
               tos_d = nos_q;
               nos_d = w_refill;
               cnt_d = cnt_q - CW'(1);
            end
            OP_DUP: begin
               nos_d      = tos_q;
               cnt_d      = cnt_q + CW'(1);
               w_spill_we = (cnt_q >= CW'(2));
            end
            OP_SWAP: begin
               tos_d = nos_q;
               nos_d = tos_q;
            end
            OP_OVER: begin
               // old nos is both the new tos and the spilled word
               tos_d      = nos_q;
               nos_d      = tos_q;
               cnt_d      = cnt_q + CW'(1);
               w_spill_we = 1'b1;
            end
            OP_REDUCE: begin
               tos_d = bus.alu_result;
               nos_d = w_refill;
               cnt_d = cnt_q - CW'(1);
            end
            OP_REPLACE: begin
               tos_d = bus.alu_result;
            end
            default: begin
               tos_d = tos_q;
            end
         endcase
      end

      // A new error in the same cycle as err_clr leaves the flag set.
      ovf_d = (ovf_q & ~bus.err_clr) | w_set_ovf;
      unf_d = (unf_q & ~bus.err_clr) | w_set_unf;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tos_q <= '0;
         nos_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         tos_q <= tos_d;
         nos_q <= nos_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // ---------------------------------------------------------------------
   // Spill register file (always receives the old nos on a spill)
   // ---------------------------------------------------------------------
   stack_spill_rf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_spill (
      .clk     (clk),
      .we_i    (w_spill_we),
      .ptr_i   (w_spill_ptr),
      .wdata_i (nos_q),
      .rdata_o (w_spill_rdata)
   );

   // ---------------------------------------------------------------------
   // Outputs: all driven from registered state only
   // ---------------------------------------------------------------------
   assign bus.op_ready  = w_ready;
   assign bus.tos       = tos_q;
   assign bus.nos       = nos_q;
   assign bus.count     = cnt_q;
   assign bus.empty     = (cnt_q == '0);
   assign bus.full      = (cnt_q == CW'(DEPTH));
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;

endmodule : stack_unit
`default_nettype wire

// File: tb/tb_stack_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_stack_unit
// Purpose : Self-checking bench for stack_unit. Three instances:
//           A = DEPTH 4 halting, B = DEPTH 16 halting, C = DEPTH 4 flag-only.
//           A reference model predicts each step; expectations are queued
//           when the op is driven and popped when the DUT has updated.
// Revision: 1.0  initial release
// ============================================================================
module tb_stack_unit;
   import stack_pkg::*;

   localparam int W  = 32;
   localparam int DA = 0;
   localparam int DB = 1;
   localparam int DC = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   stack_if #(.WIDTH(W), .DEPTH(4))  if_a ();
   stack_if #(.WIDTH(W), .DEPTH(16)) if_b ();
   stack_if #(.WIDTH(W), .DEPTH(4))  if_c ();

   stack_unit #(.WIDTH(W), .DEPTH(4),  .HALT_ON_ERR(1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
   stack_unit #(.WIDTH(W), .DEPTH(16), .HALT_ON_ERR(1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
   stack_unit #(.WIDTH(W), .DEPTH(4),  .HALT_ON_ERR(0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

   typedef struct {
      int         d;
      logic [W-1:0] tos;
      logic [W-1:0] nos;
      int         cnt;
      logic       empty;
      logic       full;
      logic       ovf;
      logic       unf;
      logic       rdy;
   } exp_t;

   exp_t         sb [$];
   logic [W-1:0] m_mem [3][16];
   int           m_cnt [3];
   bit           m_ovf [3];
   bit           m_unf [3];
   int           n_checks = 0;
   int           n_err    = 0;

   function automatic int depth_of(int d);
      return (d == DB) ? 16 : 4;
   endfunction

   function automatic bit halt_of(int d);
      return (d != DC);
   endfunction

   task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      for (int d = 0; d < 3; d++) begin
         m_cnt[d] = 0;
         m_ovf[d] = 1'b0;
         m_unf[d] = 1'b0;
      end
   endfunction

   function automatic exp_t model_exp(int d);
      exp_t e;
      int   c = m_cnt[d];
      e.d     = d;
      e.cnt   = c;
      e.tos   = '0;
      e.nos   = '0;
      if (c >= 1) e.tos = m_mem[d][c-1];
      if (c >= 2) e.nos = m_mem[d][c-2];
      e.empty = (c == 0);
      e.full  = (c == depth_of(d));
      e.ovf   = m_ovf[d];
      e.unf   = m_unf[d];
      e.rdy   = halt_of(d) ? !(m_ovf[d] || m_unf[d]) : 1'b1;
      return e;
   endfunction

   function automatic void model_step(int d, logic [2:0] op, logic [W-1:0] pd,
                                      logic [W-1:0] alu, bit clr);
      op_req_t      r   = op_req(op);
      int           c   = m_cnt[d];
      bit           rdy = halt_of(d) ? !(m_ovf[d] || m_unf[d]) : 1'b1;
      bit           so  = 1'b0;
      bit           su  = 1'b0;
      logic [W-1:0] t;
      if (rdy) begin
         if (c < int'(r.min_entries)) su = 1'b1;
         else if (r.grows && c == depth_of(d)) so = 1'b1;
         else begin
            case (op)
               OP_PUSH:    begin m_mem[d][c] = pd; m_cnt[d] = c + 1; end
               OP_DROP:    m_cnt[d] = c - 1;
               OP_DUP:     begin m_mem[d][c] = m_mem[d][c-1]; m_cnt[d] = c + 1; end
               OP_SWAP:    begin
                  t = m_mem[d][c-1];
                  m_mem[d][c-1] = m_mem[d][c-2];
                  m_mem[d][c-2] = t;
               end
               OP_OVER:    begin m_mem[d][c] = m_mem[d][c-2]; m_cnt[d] = c + 1; end
               OP_REDUCE:  begin m_mem[d][c-2] = alu; m_cnt[d] = c - 1; end
               OP_REPLACE: m_mem[d][c-1] = alu;
               default:    ;
            endcase
         end
      end
      m_ovf[d] = (m_ovf[d] && !clr) || so;
      m_unf[d] = (m_unf[d] && !clr) || su;
      sb.push_back(model_exp(d));
   endfunction

   task automatic observe(input int d, output exp_t o);
      o.d = d;
      case (d)
         DA: begin
            o.tos = if_a.tos; o.nos = if_a.nos; o.cnt = int'(if_a.count);
            o.empty = if_a.empty; o.full = if_a.full; o.ovf = if_a.overflow;
            o.unf = if_a.underflow; o.rdy = if_a.op_ready;
         end
         DB: begin
            o.tos = if_b.tos; o.nos = if_b.nos; o.cnt = int'(if_b.count);
            o.empty = if_b.empty; o.full = if_b.full; o.ovf = if_b.overflow;
            o.unf = if_b.underflow; o.rdy = if_b.op_ready;
         end
         default: begin
            o.tos = if_c.tos; o.nos = if_c.nos; o.cnt = int'(if_c.count);
            o.empty = if_c.empty; o.full = if_c.full; o.ovf = if_c.overflow;
            o.unf = if_c.underflow; o.rdy = if_c.op_ready;
         end
      endcase
   endtask

   task automatic compare(string tag);
      exp_t e;
      exp_t o;
      e = sb.pop_front();
      observe(e.d, o);
      chk({tag, ".tos"},   o.tos, e.tos);
      chk({tag, ".nos"},   o.nos, e.nos);
      chk({tag, ".count"}, 32'(o.cnt), 32'(e.cnt));
      chk({tag, ".empty"}, 32'(o.empty), 32'(e.empty));
      chk({tag, ".full"},  32'(o.full), 32'(e.full));
      chk({tag, ".ovf"},   32'(o.ovf), 32'(e.ovf));
      chk({tag, ".unf"},   32'(o.unf), 32'(e.unf));
      chk({tag, ".ready"}, 32'(o.rdy), 32'(e.rdy));
   endtask

   task automatic idle();
      if_a.op_valid = 1'b0; if_a.op = OP_NOP; if_a.push_data = '0; if_a.alu_result = '0; if_a.err_clr = 1'b0;
      if_b.op_valid = 1'b0; if_b.op = OP_NOP; if_b.push_data = '0; if_b.alu_result = '0; if_b.err_clr = 1'b0;
      if_c.op_valid = 1'b0; if_c.op = OP_NOP; if_c.push_data = '0; if_c.alu_result = '0; if_c.err_clr = 1'b0;
   endtask

   task automatic step(int d, logic [2:0] op, logic [W-1:0] pd, logic [W-1:0] alu,
                       bit clr, string tag);
      case (d)
         DA: begin if_a.op_valid = 1'b1; if_a.op = op; if_a.push_data = pd; if_a.alu_result = alu; if_a.err_clr = clr; end
         DB: begin if_b.op_valid = 1'b1; if_b.op = op; if_b.push_data = pd; if_b.alu_result = alu; if_b.err_clr = clr; end
         default: begin if_c.op_valid = 1'b1; if_c.op = op; if_c.push_data = pd; if_c.alu_result = alu; if_c.err_clr = clr; end
      endcase
      model_step(d, op, pd, alu, clr);
      @(posedge clk);
      #1;
      idle();
      compare(tag);
   endtask

   task automatic push(int d, logic [W-1:0] v);
      step(d, OP_PUSH, v, '0, 1'b0, "push");
   endtask

   task automatic op1(int d, logic [2:0] op, string tag);
      step(d, op, '0, '0, 1'b0, tag);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      model_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         sb.push_back(model_exp(d));
         compare("reset");
      end

      // ---- B: SWAP / OVER ----
      push(DB, 32'd5);
      push(DB, 32'd7);
      op1(DB, OP_SWAP, "swap");
      chk("swap.tos_dir", if_b.tos, 32'd5);
      chk("swap.nos_dir", if_b.nos, 32'd7);
      chk("swap.cnt_dir", 32'(if_b.count), 32'd2);
      op1(DB, OP_OVER, "over");
      chk("over.tos_dir", if_b.tos, 32'd7);
      chk("over.nos_dir", if_b.nos, 32'd5);
      chk("over.cnt_dir", 32'(if_b.count), 32'd3);
      repeat (3) op1(DB, OP_DROP, "drop");

      // ---- B: REDUCE / REPLACE ----
      push(DB, 32'd10);
      push(DB, 32'd20);
      push(DB, 32'd30);
      step(DB, OP_REDUCE, '0, 32'd50, 1'b0, "reduce");
      chk("reduce.tos_dir", if_b.tos, 32'd50);
      chk("reduce.nos_dir", if_b.nos, 32'd10);
      chk("reduce.cnt_dir", 32'(if_b.count), 32'd2);
      step(DB, OP_REPLACE, '0, 32'd1, 1'b0, "replace");
      chk("replace.tos_dir", if_b.tos, 32'd1);
      chk("replace.nos_dir", if_b.nos, 32'd10);
      repeat (2) op1(DB, OP_DROP, "drop");

      // ---- B: spill round trip ----
      for (int i = 0; i < 16; i++) push(DB, 32'(i));
      chk("spill.full_dir", 32'(if_b.full), 32'd1);
      for (int i = 0; i < 14; i++) op1(DB, OP_DROP, "spill_drop");
      chk("spill.tos_dir", if_b.tos, 32'd1);
      chk("spill.nos_dir", if_b.nos, 32'd0);
      chk("spill.cnt_dir", 32'(if_b.count), 32'd2);
      repeat (2) op1(DB, OP_DROP, "drop");

      // ---- B: err_clr together with an illegal DUP ----
      step(DB, OP_DUP, '0, '0, 1'b1, "dup_clr");
      chk("dup_clr.unf_dir", 32'(if_b.underflow), 32'd1);
      step(DB, OP_NOP, '0, '0, 1'b1, "clr");
      chk("clr.ready_dir", 32'(if_b.op_ready), 32'd1);

      // ---- A: overflow with halt ----
      for (int i = 1; i <= 4; i++) push(DA, 32'(i));
      push(DA, 32'd9);
      chk("ovf.flag_dir",  32'(if_a.overflow), 32'd1);
      chk("ovf.cnt_dir",   32'(if_a.count), 32'd4);
      chk("ovf.tos_dir",   if_a.tos, 32'd4);
      chk("ovf.ready_dir", 32'(if_a.op_ready), 32'd0);
      push(DA, 32'd11);
      step(DA, OP_NOP, '0, '0, 1'b1, "ovf_clr");
      chk("ovf_clr.ready_dir", 32'(if_a.op_ready), 32'd1);
      chk("ovf_clr.flag_dir",  32'(if_a.overflow), 32'd0);
      step(DA, OP_DUP, '0, '0, 1'b1, "dup_full_clr");
      chk("dup_full_clr.ovf_dir", 32'(if_a.overflow), 32'd1);
      step(DA, OP_NOP, '0, '0, 1'b1, "clr");

      // ---- C: flag-only mode ----
      op1(DC, OP_DROP, "c_drop_empty");
      chk("c_unf.flag_dir",  32'(if_c.underflow), 32'd1);
      chk("c_unf.tos_dir",   if_c.tos, 32'd0);
      chk("c_unf.ready_dir", 32'(if_c.op_ready), 32'd1);
      push(DC, 32'd3);
      chk("c_push.tos_dir", if_c.tos, 32'd3);
      step(DC, OP_NOP, '0, '0, 1'b1, "clr");
      op1(DC, OP_SWAP, "c_swap1");
      step(DC, OP_NOP, '0, '0, 1'b1, "clr");
      op1(DC, OP_OVER, "c_over1");
      step(DC, OP_NOP, '0, '0, 1'b1, "clr");
      op1(DC, OP_REDUCE, "c_reduce1");
      step(DC, OP_NOP, '0, '0, 1'b1, "clr");
      push(DC, 32'hFFFF_FFFF);
      push(DC, 32'd5);
      push(DC, 32'd6);
      op1(DC, OP_OVER, "c_over_full");
      chk("c_over_full.ovf_dir", 32'(if_c.overflow), 32'd1);
      op1(DC, OP_DROP, "c_drop_after_err");
      op1(DC, OP_DROP, "c_drop");

      // ---- B: pseudo-random ops against the model ----
      for (int i = 0; i < 120; i++) begin
         step(DB, 3'($urandom_range(0, 7)), $urandom, $urandom,
              ($urandom_range(0, 5) == 0), "rand");
      end

      // ---- asynchronous reset mid-sequence with an op pending ----
      push(DB, 32'd11);
      push(DB, 32'd22);
      if_b.op_valid = 1'b1;
      if_b.op       = OP_PUSH;
      if_b.push_data = 32'd99;
      #2 rst = 1'b0;
      #1;
      chk("arst.tos",   if_b.tos, 32'd0);
      chk("arst.nos",   if_b.nos, 32'd0);
      chk("arst.count", 32'(if_b.count), 32'd0);
      chk("arst.empty", 32'(if_b.empty), 32'd1);
      chk("arst.full",  32'(if_b.full), 32'd0);
      chk("arst.ovf",   32'(if_b.overflow), 32'd0);
      chk("arst.unf",   32'(if_b.underflow), 32'd0);
      chk("arst.ready", 32'(if_b.op_ready), 32'd1);
      idle();
      #2 rst = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++) begin
         sb.push_back(model_exp(d));
         compare("post_reset");
      end
      push(DB, 32'd42);
      chk("post_reset.push_dir", if_b.tos, 32'd42);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule : tb_stack_unit
`default_nettype wire

// File: doc/stack_unit.md
Name: stack_unit

Overview:
Parametrised operand stack for the StackArch CPU. It replaces the fixed-size datapath stack with one whose width and depth are set by parameters. The two top entries are held in registers and deeper entries spill to a register file. It adds stack-manipulation ops (DUP/SWAP/OVER), ALU write-back ops, sticky overflow/underflow detection and an optional halt-on-error handshake. It sits between the CPU control unit (which issues ops) and the ALU (which consumes tos/nos and returns alu_result).

Parameters:
WIDTH, 32, data word width in bits
DEPTH, 16, maximum number of entries; must be a power of two and at least 4
HALT_ON_ERR, 1, when 1, op_ready drops after any error until err_clr; when 0, errors are only flagged

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
op_valid  in  1  op request
op_ready  out  1  unit accepts an op this cycle
op  in  3  0 NOP, 1 PUSH, 2 DROP, 3 DUP, 4 SWAP, 5 OVER, 6 REDUCE, 7 REPLACE
push_data  in  WIDTH  operand for PUSH
alu_result  in  WIDTH  operand for REDUCE/REPLACE
tos  out  WIDTH  top of stack; 0 when count<1
nos  out  WIDTH  next-on-stack; 0 when count<2
count  out  $clog2(DEPTH)+1  current number of entries
empty  out  1  count==0
full  out  1  count==DEPTH
overflow  out  1  sticky; an op needed more room than was free
underflow  out  1  sticky; an op needed more entries than were present
err_clr  in  1  clears overflow/underflow and re-enables op_ready

Behaviour:
- Reset (rst=0, asynchronous): tos=0, nos=0, count=0, empty=1, full=0, overflow=0, underflow=0, op_ready=1. Spill file contents are don't-care.
- An op fires on a rising clk when op_valid && op_ready. All outputs are registered and reflect the new state in the following cycle. Throughput is 1 op/cycle and there are no combinational paths from inputs to outputs.
- Op effects, with a..b being the old tos..nos and c the old third entry:
  - PUSH: count+1; tos=push_data; nos=a; old b spills.
  - DROP: count-1; tos=b; nos=c (refilled from spill, or 0 if absent).
  - DUP: count+1; tos=a; nos=a; b spills.
  - SWAP: tos=b; nos=a; count unchanged.
  - OVER: count+1; tos=b; nos=a; b spills.
  - REDUCE: count-1; tos=alu_result; nos=c.
  - REPLACE: tos=alu_result; count unchanged.
  - NOP: no change.
- Legality:
  - Min entries: DROP/DUP/REPLACE need 1; SWAP/OVER/REDUCE need 2.
  - Growth: PUSH/DUP/OVER need count<DEPTH.
  - On an illegal op, state is unchanged and the matching sticky flag sets. Underflow is checked first; an op sets at most one flag.
- err_clr and a new error in the same cycle: the error wins and the flag stays or becomes 1.
- With HALT_ON_ERR=1, op_ready=!(overflow|underflow).
  - Ops presented while op_ready=0 are ignored and do not raise new flags.
  - err_clr in cycle n gives op_ready=1 in cycle n+1.
- With HALT_ON_ERR=0, op_ready is constantly 1.
- Spill file: DEPTH-2 entries, indexed by a pointer equal to count-2. Only one write or one read per cycle. Pointer wrap cannot occur because the legality checks block it.
- Values wrap silently at WIDTH; the unit performs no arithmetic.
- Reset asserted mid-sequence aborts any in-flight op. No partial update is permitted.

Decomposition:
- Package stack_pkg: op encoding localparams (OP_NOP..OP_REPLACE) and a min-entries/growth lookup function used by both the RTL and the bench.
- One natural sub-module, stack_spill_rf: a DEPTH-2 x WIDTH register file with one synchronous write port and an asynchronous read at ptr-1.

Test Plan:
- PUSH 5, PUSH 7, SWAP -> tos=5, nos=7, count=2; then OVER -> tos=7, nos=5, count=3.
- DEPTH=4: PUSH 1..4, then PUSH 9 -> overflow=1, count=4, tos=4, op_ready=0; next PUSH ignored; err_clr -> op_ready=1 next cycle, overflow=0.
- Empty stack: DROP -> underflow=1, count=0, tos=0. Repeat with HALT_ON_ERR=0 -> op_ready stays 1 and the next PUSH 3 gives tos=3.
- PUSH 10, PUSH 20, PUSH 30, REDUCE with alu_result=50 -> tos=50, nos=10, count=2; REPLACE with alu_result=1 -> tos=1, nos=10.
- Spill round-trip at DEPTH=16: PUSH 0..15 (full=1), then 14 DROPs -> tos=1, nos=0, count=2, with correct values at every step.
- Pulse rst low mid-sequence, off a clk edge -> all outputs reach their reset values immediately. err_clr together with an illegal DUP on an empty stack -> underflow remains 1.
